// File: rtl/ras_ckpt.sv
// Return-address stack with single-slot checkpoint/restore for the frontend predictor.
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   flush_i             clear stack and checkpoint slot
//   push_i/push_addr_i  push a return address (call)
//   pop_i               pop the top entry (return)
//   ckpt_i/restore_i    save current stack state / restore it from the slot
//   top_valid_o/top_addr_o  combinational view of the registered top entry
//   ckpt_valid_o        slot holds a saved state
//   overflow_o/underflow_o  registered one-cycle pulses on push-full / pop-empty
module ras_ckpt #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned VLEN  = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [VLEN-1:0] push_addr_i,
  input  logic            pop_i,
  input  logic            ckpt_i,
  input  logic            restore_i,
  output logic            top_valid_o,
  output logic [VLEN-1:0] top_addr_o,
  output logic            ckpt_valid_o,
  output logic            overflow_o,
  output logic            underflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_valid;
  logic [VLEN-1:0]  mem_addr [DEPTH];
  logic [PW-1:0]    tos;
  logic [CW-1:0]    count;

  logic [PW-1:0]    ckpt_tos;
  logic [CW-1:0]    ckpt_count;
  logic             ckpt_entry_valid;
  logic [VLEN-1:0]  ckpt_entry_addr;
  logic             ckpt_valid;

  logic             overflow;
  logic             underflow;

  logic [PW-1:0]    tos_inc;
  logic [PW-1:0]    tos_dec;
  logic             full;
  logic             empty;

  // DEPTH is a power of two, so natural PW-bit overflow gives the modulo wrap.
  assign tos_inc = tos + PW'(1);
  assign tos_dec = tos - PW'(1);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  // Stack, checkpoint slot and status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      mem_valid        <= '0;
      for (int i = 0; i < DEPTH; i++) mem_addr[i] <= '0;
      tos              <= '0;
      count            <= '0;
      ckpt_tos         <= '0;
      ckpt_count       <= '0;
      ckpt_entry_valid <= 1'b0;
      ckpt_entry_addr  <= '0;
      ckpt_valid       <= 1'b0;
      overflow         <= 1'b0;
      underflow        <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;

      if (restore_i) begin
        // Without a saved state the only safe repair is an empty stack.
        if (ckpt_valid) begin
          tos                <= ckpt_tos;
          count              <= ckpt_count;
          mem_valid[ckpt_tos] <= ckpt_entry_valid;
          mem_addr[ckpt_tos]  <= ckpt_entry_addr;
        end else begin
          mem_valid <= '0;
          for (int i = 0; i < DEPTH; i++) mem_addr[i] <= '0;
          tos   <= '0;
          count <= '0;
        end
      end else if (push_i && pop_i) begin
        // Coroutine call/return: replace the top in place.
        mem_valid[tos] <= 1'b1;
        mem_addr[tos]  <= push_addr_i;
        if (empty) count <= CW'(1);
      end else if (push_i) begin
        tos                <= tos_inc;
        mem_valid[tos_inc] <= 1'b1;
        mem_addr[tos_inc]  <= push_addr_i;
        if (full) overflow <= 1'b1;
        else      count    <= count + CW'(1);
      end else if (pop_i) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          mem_valid[tos] <= 1'b0;
          tos            <= tos_dec;
          count          <= count - CW'(1);
        end
      end

      // Checkpoint captures the pre-update state; alongside a restore it takes
      // the restored state, which equals the old slot when that slot was valid.
      if (ckpt_i) begin
        ckpt_valid <= 1'b1;
        if (!restore_i) begin
          ckpt_tos         <= tos;
          ckpt_count       <= count;
          ckpt_entry_valid <= mem_valid[tos];
          ckpt_entry_addr  <= mem_addr[tos];
        end else if (!ckpt_valid) begin
          ckpt_tos         <= '0;
          ckpt_count       <= '0;
          ckpt_entry_valid <= 1'b0;
          ckpt_entry_addr  <= '0;
        end
      end
    end
  end

  assign top_valid_o  = !empty && mem_valid[tos];
  assign top_addr_o   = mem_addr[tos];
  assign ckpt_valid_o = ckpt_valid;
  assign overflow_o   = overflow;
  assign underflow_o  = underflow;

endmodule
